poly_stream_arbiter: RTL and testbench
======================================

// Module: poly_stream_arbiter
// PURPOSE
//  Shares one downstream polynomial arithmetic unit (NTT/pointwise-mult/add) between NUM_REQ
//  AXI4-Stream requesters at whole-polynomial granularity. Round-robin grant, locked for exactly
//  BEATS_PER_POLY beats (256 coeffs x 16b = 16 beats of 256b), with controller-generated TLAST and a TID tag.
// PARAMETERS
//  NUM_REQ         2                  number of requesting streams (2..8)
//  DWIDTH          pkg DWIDTH (256)   stream data width
//  BEATS_PER_POLY  pkg BEATS_PER_POLY (16)  beats per grant; power of two
// PORTS
//  clk            in   1                   single clock
//  rst            in   1                   asynchronous, active-high reset
//  s_axis_tdata   in   NUM_REQ x DWIDTH    requester data
//  s_axis_tvalid  in   NUM_REQ             requester valid
//  s_axis_tlast   in   NUM_REQ             requester last (checked only, see CONFIGURATION)
//  s_axis_tready  out  NUM_REQ             requester ready
//  m_axis_tdata   out  DWIDTH              to arithmetic unit
//  m_axis_tvalid  out  1                   to arithmetic unit
//  m_axis_tlast   out  1                   high on beat BEATS_PER_POLY-1 of each grant
//  m_axis_tid     out  $clog2(NUM_REQ)     index of granted requester
//  m_axis_tready  in   1                   from arithmetic unit
//  busy           out  1                   grant held
//  err_tlast      out  1                   one-cycle pulse on TLAST mismatch
// BEHAVIOUR
//  Reset (async, any time incl. mid-poly): state=IDLE, beat_cnt=0, rr_ptr=0, grant=0; therefore
//   m_axis_tvalid=0, s_axis_tready=0, m_axis_tlast=0, m_axis_tid=0, busy=0, err_tlast=0. No partial
//   poly is resumed; the upstream requester is responsible for restarting.
//  FSM IDLE: all s_axis_tready=0, m_axis_tvalid=0. If any s_axis_tvalid: pick first valid index
//   searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ); register grant, ->LOCK. Arbitration costs exactly
//   one bubble cycle; no data passes in IDLE.
//  FSM LOCK: pure combinational pass-through of granted lane: m_axis_tdata/tvalid = lane[grant],
//   s_axis_tready[grant]=m_axis_tready, other lanes ready=0. m_axis_tid=grant, busy=1.
//   Beat = m_axis_tvalid & m_axis_tready; beat_cnt++ per beat. m_axis_tlast = (beat_cnt==BEATS_PER_POLY-1).
//   On beat with beat_cnt==BEATS_PER_POLY-1: beat_cnt->0, rr_ptr->(grant+1) mod NUM_REQ, ->IDLE.
//  Grant is never revoked: granted lane dropping tvalid stalls the unit; other valids wait.
//  m_axis_tready low holds everything; AXI rule: tdata/tvalid stable is upstream's duty (pass-through).
//  Simultaneous requests: rotation guarantees each valid lane a grant within NUM_REQ polys.
//  NUM_REQ=1: rr_ptr constant 0; still one bubble between polys.
//  beat_cnt width $clog2(BEATS_PER_POLY); wraps naturally at last beat.
// CONFIGURATION
//  POLY_ARB_TLAST_CHECK_EN defined: on each beat, err_tlast pulses (next cycle, registered) if
//   s_axis_tlast[grant] != m_axis_tlast. Stream is NOT altered; beat count still governs release.
//  Not defined: s_axis_tlast ignored, err_tlast tied 0.
// STRUCTURE
//  poly_arith_pkg additions: BEAT_CNT_W = $clog2(BEATS_PER_POLY); typedef logic [BEAT_CNT_W-1:0]
//   beat_cnt_t; typedef enum logic {ARB_IDLE, ARB_LOCK} poly_arb_state_t.
//  Sub-module poly_rr_picker: combinational round-robin picker (req vector, rr_ptr -> valid, index).
//  Top holds FSM, beat counter, grant/rr_ptr regs, mux, TLAST check.
// TESTING
//  1 Reset: hold rst, drive all tvalid=1 -> all outputs 0; release -> IDLE 1 cycle, then grant lane 0.
//  2 Single lane: lane1 sends 16 beats, m_tready=1 -> m_tid=1, m_tlast only on beat 16, busy drops after,
//    data bit-exact.
//  3 Contention NUM_REQ=3: all lanes continuously valid -> grant order 0,1,2,0; exactly 1 bubble between polys.
//  4 Backpressure: m_tready toggling 1/0 and lane tvalid gaps -> 16 beats delivered, no loss/duplicate,
//    other lanes ready=0 throughout.
//  5 TLAST check (macro on): lane asserts s_tlast on beat 10 -> err_tlast pulses once the cycle after
//    beat 10 and again after beat 16 (missing tlast); grant still released after beat 16. Macro off: err_tlast=0.
//  6 Reset mid-poly at beat 7 -> outputs 0 immediately (async); after release new poly starts at beat_cnt 0,
//    rr_ptr 0.

Source files
------------

// File: rtl/poly_arith_pkg.sv
// Shared types and constants for the polynomial arithmetic stream blocks.
package poly_arith_pkg;

   localparam int unsigned DWIDTH         = 256;
   localparam int unsigned BEATS_PER_POLY = 16;
   localparam int unsigned BEAT_CNT_W     = $clog2(BEATS_PER_POLY);

   typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

   typedef enum logic {ARB_IDLE, ARB_LOCK} poly_arb_state_t;

   // Index width that stays at least one bit for a single requester.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/poly_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping mod NUM_REQ.
module poly_rr_picker
   import poly_arith_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 2,
   localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic               valid_o,
   output logic [ID_W-1:0]    idx_o
);

   logic [ID_W:0] cand;

   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, ptr_i} + (ID_W+1)'(i);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         if (!valid_o && req_i[cand[ID_W-1:0]]) begin
            valid_o = 1'b1;
            idx_o   = cand[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/poly_stream_arbiter.sv
// Whole-polynomial round-robin arbiter in front of a shared arithmetic unit.
// Optional TLAST cross-check enabled by defining POLY_ARB_TLAST_CHECK_EN.
module poly_stream_arbiter
   import poly_arith_pkg::*;
#(
   parameter  int unsigned NUM_REQ        = 2,
   parameter  int unsigned DWIDTH         = poly_arith_pkg::DWIDTH,
   parameter  int unsigned BEATS_PER_POLY = poly_arith_pkg::BEATS_PER_POLY,
   localparam int unsigned ID_W           = id_width(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0][DWIDTH-1:0]  s_axis_tdata,
   input  logic [NUM_REQ-1:0]              s_axis_tvalid,
   input  logic [NUM_REQ-1:0]              s_axis_tlast,
   output logic [NUM_REQ-1:0]              s_axis_tready,
   output logic [DWIDTH-1:0]               m_axis_tdata,
   output logic                            m_axis_tvalid,
   output logic                            m_axis_tlast,
   output logic [ID_W-1:0]                 m_axis_tid,
   input  logic                            m_axis_tready,
   output logic                            busy,
   output logic                            err_tlast
);

   localparam int unsigned     CNT_W     = $clog2(BEATS_PER_POLY);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_POLY - 1);
   localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

   poly_arb_state_t  state_q, state_d;
   logic [ID_W-1:0]  grant_q, grant_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [ID_W-1:0]  pick_idx;
   logic             pick_valid;
   logic             beat;

   poly_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req_i   (s_axis_tvalid),
      .ptr_i   (rr_ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   assign beat = m_axis_tvalid & m_axis_tready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ARB_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Grant is latched in IDLE and held until the last beat of the poly completes.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               state_d = ARB_LOCK;
            end
         end
         ARB_LOCK: begin
            if (beat) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               if (beat_cnt_q == LAST_BEAT) begin
                  rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + ID_W'(1);
                  state_d  = ARB_IDLE;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      m_axis_tdata  = s_axis_tdata[grant_q];
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tid    = grant_q;
      s_axis_tready = '0;
      busy          = 1'b0;
      if (state_q == ARB_LOCK) begin
         m_axis_tvalid          = s_axis_tvalid[grant_q];
         m_axis_tlast           = (beat_cnt_q == LAST_BEAT);
         s_axis_tready[grant_q] = m_axis_tready;
         busy                   = 1'b1;
      end
   end

`ifdef POLY_ARB_TLAST_CHECK_EN
   logic err_q, err_d;

   assign err_d = beat & (s_axis_tlast[grant_q] != m_axis_tlast);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign err_tlast = err_q;
`else
   logic unused_tlast;

   assign unused_tlast = ^s_axis_tlast;
   assign err_tlast    = 1'b0;
`endif

endmodule

// File: tb/tb_poly_stream_arbiter.sv
// Directed scoreboard bench for poly_stream_arbiter with three requesters.
`timescale 1ns/1ps
module tb_poly_stream_arbiter;
   import poly_arith_pkg::*;

   localparam int unsigned NR  = 3;
   localparam int unsigned DW  = 256;
   localparam int unsigned BP  = 16;
   localparam int unsigned IDW = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NR-1:0][DW-1:0] s_tdata;
   logic [NR-1:0]         s_tvalid, s_tlast, s_tready;
   logic [DW-1:0]         m_tdata;
   logic                  m_tvalid, m_tlast, m_tready;
   logic [IDW-1:0]        m_tid;
   logic                  busy, err_tlast;

   always #5 clk = ~clk;

   poly_stream_arbiter #(.NUM_REQ(NR), .DWIDTH(DW), .BEATS_PER_POLY(BP)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tid    (m_tid),
      .m_axis_tready (m_tready),
      .busy          (busy),
      .err_tlast     (err_tlast)
   );

   int          checks = 0;
   int          fails  = 0;
   int unsigned seq     [NR];
   int unsigned left    [NR];
   int unsigned enq_seq [NR];
   logic [NR-1:0] gap;
   int          epoch = 0;
   int          tl_mode = 0;
   logic [DW-1:0] exp0[$], exp1[$], exp2[$];
   int unsigned grant_exp[$];
   int          out_idx = 0;
   int unsigned cur_tid = 0;
   bit          in_poly = 0, after_last = 0, err_pend = 0;
   bit          chk_ready = 0, tready_toggle = 0, gap_rand = 0;
   int          beats_seen = 0, err_seen = 0;

   function automatic logic [DW-1:0] mkdata(input int unsigned l, input int unsigned s, input int e);
      logic [DW-1:0] d;
      d = '0;
      for (int k = 0; k < 8; k++) begin
         d[k*32 +: 32] = {4'(l), 4'(e), 8'(s), 8'(k), 8'(s*37 + l*11 + 32'(k))};
      end
      return d;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int unsigned l = 0; l < NR; l++) begin
         s_tvalid[IDW'(l)] = (left[l] != 0) && !gap[IDW'(l)];
         s_tdata[IDW'(l)]  = mkdata(l, seq[l], epoch);
         if (tl_mode == 1) s_tlast[IDW'(l)] = (seq[l] % BP == 9);
         else              s_tlast[IDW'(l)] = (seq[l] % BP == BP - 1);
      end
   endtask

   task automatic enq(input int unsigned l, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         case (l)
            0:       exp0.push_back(mkdata(l, enq_seq[l], epoch));
            1:       exp1.push_back(mkdata(l, enq_seq[l], epoch));
            default: exp2.push_back(mkdata(l, enq_seq[l], epoch));
         endcase
         enq_seq[l]++;
      end
      left[l] += n;
      drive();
   endtask

   task automatic flush();
      exp0.delete(); exp1.delete(); exp2.delete(); grant_exp.delete();
      for (int unsigned l = 0; l < NR; l++) begin
         seq[l] = 0; left[l] = 0; enq_seq[l] = 0;
      end
      gap = '0; out_idx = 0; in_poly = 0; after_last = 0; err_pend = 0; beats_seen = 0;
      drive();
   endtask

   task automatic monitor_beat();
      logic [DW-1:0] e;
      int sz;
      e = '0;
      if (out_idx == 0) begin
         chk("grant_pending", DW'(grant_exp.size() != 0), DW'(1));
         if (grant_exp.size() != 0) cur_tid = grant_exp.pop_front();
         in_poly = 1;
      end
      chk("m_tid", DW'(m_tid), DW'(cur_tid));
      chk("m_tlast", DW'(m_tlast), DW'(out_idx == BP - 1));
      case (cur_tid)
         0:       sz = exp0.size();
         1:       sz = exp1.size();
         default: sz = exp2.size();
      endcase
      chk("data_pending", DW'(sz != 0), DW'(1));
      if (sz != 0) begin
         case (cur_tid)
            0:       e = exp0.pop_front();
            1:       e = exp1.pop_front();
            default: e = exp2.pop_front();
         endcase
         chk("m_tdata", m_tdata, e);
      end
`ifdef POLY_ARB_TLAST_CHECK_EN
      err_pend = (s_tlast[IDW'(cur_tid)] != (out_idx == BP - 1));
`endif
      beats_seen++;
      if (out_idx == BP - 1) begin
         out_idx = 0; in_poly = 0; after_last = 1;
      end else begin
         out_idx++;
      end
   endtask

   // One clock: sample at negedge, advance sources after posedge.
   task automatic cycle();
      logic [NR-1:0] acc;
      @(negedge clk);
      chk("err_tlast", DW'(err_tlast), DW'(err_pend));
      if (err_tlast === 1'b1) err_seen++;
      err_pend = 0;
      if (after_last) begin
         chk("bubble_tvalid", DW'(m_tvalid), DW'(0));
         after_last = 0;
      end
      if (chk_ready && in_poly)
         chk("lane_ready", DW'(s_tready), DW'(m_tready ? (NR'(1) << cur_tid) : NR'(0)));
      if (m_tvalid === 1'b1 && m_tready === 1'b1) monitor_beat();
      acc = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int unsigned l = 0; l < NR; l++) begin
         if (acc[IDW'(l)]) begin
            seq[l]++;
            left[l]--;
         end
      end
      if (gap_rand) for (int unsigned l = 0; l < NR; l++) gap[IDW'(l)] = ($urandom_range(0, 3) == 0);
      if (tready_toggle) m_tready = ~m_tready;
      drive();
   endtask

   task automatic run_beats(input int target, input int budget);
      int n;
      n = 0;
      while (beats_seen < target && n < budget) begin
         cycle();
         n++;
      end
      chk("beat_timeout", DW'(beats_seen >= target), DW'(1));
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_m_tvalid"}, DW'(m_tvalid), DW'(0));
      chk({tag, "_s_tready"}, DW'(s_tready), DW'(0));
      chk({tag, "_m_tlast"},  DW'(m_tlast),  DW'(0));
      chk({tag, "_m_tid"},    DW'(m_tid),    DW'(0));
      chk({tag, "_busy"},     DW'(busy),     DW'(0));
      chk({tag, "_err"},      DW'(err_tlast), DW'(0));
   endtask

   initial begin
      int n;
      rst = 1'b1;
      m_tready = 1'b1;
      flush();

      // Reset with every lane requesting, then contention 0,1,2,0.
      enq(0, 32); enq(1, 16); enq(2, 16);
      grant_exp.push_back(0); grant_exp.push_back(1);
      grant_exp.push_back(2); grant_exp.push_back(0);
      repeat (3) @(posedge clk);
      #1;
      chk_quiet("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      chk("idle_after_reset_busy", DW'(busy), DW'(0));
      cycle();
      chk("first_grant_busy", DW'(busy), DW'(1));
      chk("first_grant_tid", DW'(m_tid), DW'(0));
      n = 1;
      while (beats_seen < 64 && n < 200) begin
         cycle();
         n++;
      end
      chk("contention_cycles", DW'(n), DW'(68));

      // Single lane 1.
      enq(1, 16); grant_exp.push_back(1);
      run_beats(beats_seen + 16, 40);
      chk("single_busy_drop", DW'(busy), DW'(0));

      // Backpressure and source gaps, lane 0 waiting behind lane 2.
      enq(2, 16); enq(0, 16);
      grant_exp.push_back(2); grant_exp.push_back(0);
      chk_ready = 1; tready_toggle = 1; gap_rand = 1;
      run_beats(beats_seen + 32, 400);
      chk_ready = 0; tready_toggle = 0; gap_rand = 0;
      gap = '0; m_tready = 1'b1; drive();
      cycle();
      chk("bp_queues_empty", DW'(exp0.size() + exp2.size()), DW'(0));

      // Early TLAST on beat 10 and missing TLAST on beat 16.
      tl_mode = 1; err_seen = 0;
      enq(1, 16); grant_exp.push_back(1);
      run_beats(beats_seen + 16, 40);
      cycle();
`ifdef POLY_ARB_TLAST_CHECK_EN
      chk("tlast_err_pulses", DW'(err_seen), DW'(2));
`else
      chk("tlast_err_pulses", DW'(err_seen), DW'(0));
`endif
      chk("tlast_released", DW'(busy), DW'(0));
      tl_mode = 0; drive();

      // Asynchronous reset after beat 7.
      enq(0, 16); grant_exp.push_back(0);
      run_beats(beats_seen + 7, 40);
      #2 rst = 1'b1;
      #1;
      chk_quiet("midreset");
      epoch = 1;
      flush();
      @(posedge clk);
      #1 rst = 1'b0;
      enq(1, 16); enq(2, 16);
      grant_exp.push_back(1); grant_exp.push_back(2);
      run_beats(32, 100);
      cycle();
      chk("post_reset_grants_used", DW'(grant_exp.size()), DW'(0));

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
